// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative EXE-stage divider: state encoding,
// iteration count and the divide-by-zero result constant.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH  = 32;
  // One restoring step per bit of the quotient.
  localparam int unsigned DIV_CYCLES = DIV_WIDTH;

  // Divide-by-zero quotient: all ones (remainder returns the raw dividend).
  localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Divider request/response bundle between the EXE stage and div_unit.
// Handshake: the EXE stage holds start (with operands stable) until the cycle
// in which done is high; done is a one-cycle strobe and quotient/remainder are
// valid in that cycle and hold until the next done. cancel withdraws the
// request in any cycle and suppresses a done that would otherwise fire.
interface div_unit_if #(
  parameter int unsigned WIDTH = div_unit_pkg::DIV_WIDTH
);
  logic             start;
  logic             signed_op;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [1:0]       dbg_state;

  // EXE-stage side: issues the operation, observes the result.
  modport master (
    output start, signed_op, cancel, dividend, divisor,
    input  stall_req, busy, done, quotient, remainder, dbg_state
  );

  // Divider side.
  modport slave (
    input  start, signed_op, cancel, dividend, divisor,
    output stall_req, busy, done, quotient, remainder, dbg_state
  );
endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // The extra top bit of the subtract acts as the borrow/sign flag.
  always_comb begin
    w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_dvs};
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      // Partial remainder is always below the divisor, so the shifted
      // value fits in WIDTH bits whenever the subtract borrows.
      o_rem = w_rem_sh[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for DIV/DIVU. Magnitudes are divided with
// a restoring algorithm (one bit per cycle) and signs are fixed up at the end.
// Quotient feeds LO and remainder feeds HI.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_count;
  logic             r_qsign;
  logic             r_rsign;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_dd_neg;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_dd_abs;
  logic [WIDTH-1:0] w_dv_abs;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;
  logic             w_done;

  // Operand conditioning: magnitudes and signs, signs forced to 0 for DIVU.
  always_comb begin
    w_accept   = bus.start && !bus.cancel;
    w_div_zero = (bus.divisor == '0);
    w_dd_neg   = bus.signed_op && bus.dividend[WIDTH-1];
    w_dv_neg   = bus.signed_op && bus.divisor[WIDTH-1];
    // Negating the most negative value wraps to itself, which is still the
    // correct unsigned magnitude.
    w_dd_abs   = w_dd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    w_dv_abs   = w_dv_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; cancel outranks start and step completion.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_accept) w_next_state = w_div_zero ? DIV_DONE : DIV_RUN;
      end
      DIV_RUN: begin
        if (bus.cancel)                w_next_state = DIV_IDLE;
        else if (r_count == LAST_STEP) w_next_state = DIV_DONE;
      end
      DIV_DONE: w_next_state = DIV_IDLE;
      default:  w_next_state = DIV_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, capture results in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_count     <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_count <= '0;
            r_dvs   <= w_dv_abs;
            if (w_div_zero) begin
              // Preload the final answer; zero sign flags pass it through.
              r_quo   <= WIDTH'(DIV_DZ_QUOTIENT);
              r_rem   <= bus.dividend;
              r_qsign <= 1'b0;
              r_rsign <= 1'b0;
            end else begin
              r_quo   <= w_dd_abs;
              r_rem   <= '0;
              r_qsign <= w_dd_neg ^ w_dv_neg;
              r_rsign <= w_dd_neg;
            end
          end
        end
        DIV_RUN: begin
          if (!bus.cancel) begin
            r_rem   <= w_step_rem;
            r_quo   <= w_step_quo;
            r_count <= r_count + 1'b1;
          end
        end
        DIV_DONE: begin
          if (!bus.cancel) begin
            r_quotient  <= w_fix_quo;
            r_remainder <= w_fix_rem;
          end
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up and output drive; results are visible in the done cycle and
  // then held in r_quotient/r_remainder until the next completion.
  always_comb begin
    w_fix_quo     = r_qsign ? (~r_quo + 1'b1) : r_quo;
    w_fix_rem     = r_rsign ? (~r_rem + 1'b1) : r_rem;
    w_done        = (r_state == DIV_DONE) && !bus.cancel;
    bus.done      = w_done;
    bus.busy      = (r_state == DIV_RUN);
    bus.stall_req = bus.start && !w_done && !bus.cancel;
    bus.quotient  = w_done ? w_fix_quo : r_quotient;
    bus.remainder = w_done ? w_fix_rem : r_remainder;
    bus.dbg_state = r_state;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a driver issues divisions and pushes the
// hand-computed {quotient, remainder} into a queue; a monitor pops and compares
// on every done strobe.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got q=0x%0h r=0x%0h, expected no done",
                 bus.quotient, bus.remainder);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {bus.quotient, bus.remainder}, mon_exp);
      end
    end
  end

  // Issue one division from a negedge, hold start until done, check latency
  // (cycles from the issuing cycle to done) and number of stall cycles.
  task automatic do_div(input string name, input logic sop,
                        input logic [31:0] dd, input logic [31:0] dv,
                        input logic [31:0] eq, input logic [31:0] er,
                        input int exp_lat, input int exp_stall, input bit disturb);
    int cyc;
    int stalls;
    cyc    = 0;
    stalls = 0;
    exp_q.push_back({eq, er});
    bus.signed_op = sop;
    bus.dividend  = dd;
    bus.divisor   = dv;
    bus.start     = 1'b1;
    #1;
    if (bus.stall_req === 1'b1) stalls++;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) break;
      if (bus.stall_req === 1'b1) stalls++;
      if (disturb && cyc == 5) begin
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
      end
      if (disturb && cyc == 6) begin
        bus.start   = 1'b1;
        bus.divisor = 32'd3;
      end
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({name, "_stall"}, 64'(stalls), 64'(exp_stall));
    bus.start = 1'b0;
    @(negedge clk);
    check({name, "_idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.cancel    = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_quo",   64'(bus.quotient), 64'd0);
    check("rst_rem",   64'(bus.remainder), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(DIV_IDLE));
    rst = 1'b0;
    @(negedge clk);

    do_div("u_100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33, 33, 1'b0);
    do_div("s_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 33, 1'b0);
    do_div("u_m7_2",     1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         33, 33, 1'b0);
    do_div("u_dz",       1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1,  1,  1'b0);
    do_div("s_dz",       1'b1, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF00, 1,  1,  1'b0);
    do_div("s_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33, 33, 1'b0);
    do_div("s_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33, 33, 1'b0);
    do_div("s_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 33, 33, 1'b0);
    do_div("u_0_5",      1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         33, 33, 1'b0);
    do_div("u_5_max",    1'b0, 32'd5,         32'hFFFF_FFFF, 32'd0,         32'd5,         33, 33, 1'b0);
    // Start toggled and operands changed mid-run must not affect the result.
    do_div("u_busy_start", 1'b0, 32'd1000,    32'd7,         32'd142,       32'd6,         33, 32, 1'b1);

    // Cancel at RUN step 10: no done, previous results (142, 6) retained.
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd999;
    bus.divisor   = 32'd4;
    bus.start     = 1'b1;
    repeat (11) @(negedge clk);
    check("cancel_busy_before", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    #1;
    check("cancel_stall", 64'(bus.stall_req), 64'd0);
    check("cancel_done",  64'(bus.done), 64'd0);
    @(negedge clk);
    check("cancel_busy_after", 64'(bus.busy), 64'd0);
    check("cancel_hold", {bus.quotient, bus.remainder}, {32'd142, 32'd6});
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    repeat (40) @(negedge clk);
    check("cancel_hold_late", {bus.quotient, bus.remainder}, {32'd142, 32'd6});

    // Asynchronous reset between edges in the middle of RUN.
    bus.dividend = 32'd555;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",  64'(bus.busy), 64'd0);
    check("arst_done",  64'(bus.done), 64'd0);
    check("arst_quo",   64'(bus.quotient), 64'd0);
    check("arst_rem",   64'(bus.remainder), 64'd0);
    check("arst_state", 64'(bus.dbg_state), 64'(DIV_IDLE));
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    do_div("u_100_7_again", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 33, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the bench itself loses progress.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
